// File: rtl/normalizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : normalizer_pkg
//  Description : Shared constants for the 32-bit CLZ/CTZ normalizer: FSM
//                state codes, operation modes and binary-search step limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package normalizer_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    // FSM state encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Operation select; any mode with bit 1 set is reserved (pass-through)
    localparam logic [1:0] MODE_CLZ = 2'b00;
    localparam logic [1:0] MODE_CTZ = 2'b01;

    // Binary-search steps run 0..STEP_LAST with widths 16,8,4,2,1
    localparam logic [2:0] STEP_LAST = 3'd4;

    // True for the two modes that actually shift the operand
    function automatic logic is_norm_mode(input logic [1:0] mode);
        return (mode == MODE_CLZ) || (mode == MODE_CTZ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/normalizer_32bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : normalizer_32bit_if
//  Description : Request/result handshake bundle for normalizer_32bit.
//                master = requester/consumer side, slave = normalizer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface normalizer_32bit_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [5:0]  count;
    logic        zero;

    modport master (
        output in_valid, data_in, mode, out_ready,
        input  in_ready, out_valid, data_out, count, zero
    );

    modport slave (
        input  in_valid, data_in, mode, out_ready,
        output in_ready, out_valid, data_out, count, zero
    );

endinterface
`default_nettype wire

// File: rtl/normalizer_step.sv
`default_nettype none
// ============================================================================
//  Module      : normalizer_step
//  Description : One combinational binary-search step of the normalizer.
//                Tests a window of width 16>>step at the MSB end (CLZ) or
//                LSB end (CTZ); if the window is all zeros the word is shifted
//                past it and the window width is reported as the increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module normalizer_step
    import normalizer_pkg::*;
(
    input  wire logic [31:0] i_working,
    input  wire logic [2:0]  i_step,
    input  wire logic [1:0]  i_mode,
    output logic      [31:0] o_next_working,
    output logic      [5:0]  o_count_inc
);

    logic [5:0] w_width;
    logic [5:0] w_keep;

    assign w_width = 6'd16 >> i_step;
    // Number of bits outside the tested window
    assign w_keep  = 6'd32 - w_width;

    // Shift past an all-zero window; reserved modes leave the word untouched
    always_comb begin
        o_next_working = i_working;
        o_count_inc    = 6'd0;
        case (i_mode)
            MODE_CLZ: begin
                if ((i_working >> w_keep) == 32'd0) begin
                    o_next_working = i_working << w_width;
                    o_count_inc    = w_width;
                end
            end
            MODE_CTZ: begin
                if ((i_working << w_keep) == 32'd0) begin
                    o_next_working = i_working >> w_width;
                    o_count_inc    = w_width;
                end
            end
            default: begin
                o_next_working = i_working;
                o_count_inc    = 6'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/normalizer_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : normalizer_32bit
//  Description : Multi-cycle 32-bit leading/trailing zero normalizer.
//                Accepts one operand in IDLE, runs five binary-search steps
//                in SEARCH, then presents the registered result in DONE until
//                the consumer takes it. Fixed 5-edge accept-to-result latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module normalizer_32bit
    import normalizer_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    normalizer_32bit_if.slave  bus
);

    logic [1:0]  r_state;
    logic [2:0]  r_step;
    logic [31:0] r_working;
    logic [1:0]  r_mode;
    logic [5:0]  r_acc;
    logic [31:0] r_data_out;
    logic [5:0]  r_count;
    logic        r_zero;

    logic [31:0] w_next_working;
    logic [5:0]  w_count_inc;
    logic        w_zero_result;

    normalizer_step u_step (
        .i_working      (r_working),
        .i_step         (r_step),
        .i_mode         (r_mode),
        .o_next_working (w_next_working),
        .o_count_inc    (w_count_inc)
    );

    // A shifting mode that ends with an empty word can only have started at 0;
    // the search alone stops at 31, so this case is forced to 32 below.
    assign w_zero_result = is_norm_mode(r_mode) && (w_next_working == 32'd0);

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.data_out  = r_data_out;
    assign bus.count     = r_count;
    assign bus.zero      = r_zero;

    // Control FSM, search datapath and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step     <= 3'd0;
            r_working  <= 32'd0;
            r_mode     <= MODE_CLZ;
            r_acc      <= 6'd0;
            r_data_out <= 32'd0;
            r_count    <= 6'd0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_working <= bus.data_in;
                        r_mode    <= bus.mode;
                        r_acc     <= 6'd0;
                        r_step    <= 3'd0;
                        r_state   <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    r_working <= w_next_working;
                    r_acc     <= r_acc + w_count_inc;
                    r_step    <= r_step + 3'd1;
                    if (r_step == STEP_LAST) begin
                        r_step  <= 3'd0;
                        r_state <= S_DONE;
                        if (w_zero_result) begin
                            r_data_out <= 32'd0;
                            r_count    <= 6'd32;
                            r_zero     <= 1'b1;
                        end else begin
                            r_data_out <= w_next_working;
                            r_count    <= r_acc + w_count_inc;
                            r_zero     <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
